arbitro_memoria_jogadores: RTL

Parametrised successor to the ControladoMemoria controller. Arbitrates NUM_CLIENTS requesters (validador, colisor, pontuacao, VGA, ...) onto the shared address/data bus of NUM_PLAYERS per-player board RAMs. Uses a request/grant handshake, selectable fixed-priority or round-robin arbitration, and a lock for read-modify-write sequences. Read data returns through a latency-tracked pipeline with a per-client valid pulse.

---
 rtl/arbitro_memoria_jogadores_if.sv | 35 +++
 rtl/arbitro_memoria_jogadores.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria_jogadores_if.sv
// Client/RAM bus bundle for the player-board memory arbiter.
// slave = arbiter view, master = client/RAM side view.
interface arbitro_memoria_jogadores_if #(
   parameter int DATA_W      = 64,
   parameter int ADDR_W      = 5,
   parameter int NUM_PLAYERS = 2,
   parameter int NUM_CLIENTS = 4
);
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

   logic [NUM_CLIENTS-1:0]        cli_req;
   logic [NUM_CLIENTS-1:0]        cli_we;
   logic [NUM_CLIENTS-1:0]        cli_lock;
   logic [NUM_CLIENTS*PW-1:0]     cli_player;
   logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr;
   logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata;
   logic [NUM_CLIENTS-1:0]        cli_gnt;
   logic [NUM_CLIENTS-1:0]        cli_rvalid;
   logic [DATA_W-1:0]             cli_rdata;
   logic [ADDR_W-1:0]             mem_addr;
   logic [DATA_W-1:0]             mem_wdata;
   logic [NUM_PLAYERS-1:0]        mem_wren;
   logic [NUM_PLAYERS*DATA_W-1:0] mem_rdata;
   logic                          erro_jogador;

   modport slave (
      input  cli_req, cli_we, cli_lock, cli_player, cli_addr, cli_wdata, mem_rdata,
      output cli_gnt, cli_rvalid, cli_rdata, mem_addr, mem_wdata, mem_wren, erro_jogador
   );

   modport master (
      output cli_req, cli_we, cli_lock, cli_player, cli_addr, cli_wdata, mem_rdata,
      input  cli_gnt, cli_rvalid, cli_rdata, mem_addr, mem_wdata, mem_wren, erro_jogador
   );
endinterface

// File: rtl/arbitro_memoria_jogadores.sv
// Arbitrates NUM_CLIENTS requesters onto the shared player-RAM bus: one grant per cycle,
// fixed-priority or round-robin with lock; read data returns RD_LATENCY+1 cycles after gnt.
module arbitro_memoria_jogadores #(
   parameter int DATA_W      = 64,
   parameter int ADDR_W      = 5,
   parameter int NUM_PLAYERS = 2,
   parameter int NUM_CLIENTS = 4,
   parameter int ARB_MODE    = 0,
   parameter int RD_LATENCY  = 1
) (
   input  logic clk,
   input  logic resetGeral,
   arbitro_memoria_jogadores_if.slave bus
);
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   typedef logic [CW-1:0] cid_t;
   typedef logic [PW-1:0] pid_t;

   cid_t                   ptr_q, ptr_d;
   logic                   own_vld_q;
   cid_t                   own_idx_q;
   logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
   logic [NUM_PLAYERS-1:0] wren_q, wren_d;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic                   erro_q;
   logic                   iss_vld_q;
   cid_t                   iss_id_q;
   pid_t                   iss_pl_q;
   logic                   pipe_vld_q [RD_LATENCY];
   cid_t                   pipe_id_q  [RD_LATENCY];
   pid_t                   pipe_pl_q  [RD_LATENCY];
   logic [NUM_CLIENTS-1:0] rvalid_q, rvalid_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;

   logic              own_act;
   logic              win_vld;
   cid_t              win_idx;
   int                rr_idx;
   logic              win_we;
   logic              win_lock;
   pid_t              win_pl;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              pl_ok;

   // A live owner pre-empts both arbitration modes; an owner that dropped req is released.
   always_comb begin
      own_act = own_vld_q && bus.cli_req[own_idx_q];
      win_vld = 1'b0;
      win_idx = '0;
      rr_idx  = 0;
      if (own_act) begin
         win_vld = 1'b1;
         win_idx = own_idx_q;
      end else if (ARB_MODE == 0) begin
         for (int i = NUM_CLIENTS-1; i >= 0; i--) begin
            if (bus.cli_req[i]) begin
               win_vld = 1'b1;
               win_idx = cid_t'(i);
            end
         end
      end else begin
         for (int off = NUM_CLIENTS-1; off >= 0; off--) begin
            rr_idx = int'(ptr_q) + off;
            if (rr_idx >= NUM_CLIENTS) rr_idx = rr_idx - NUM_CLIENTS;
            if (bus.cli_req[rr_idx]) begin
               win_vld = 1'b1;
               win_idx = cid_t'(rr_idx);
            end
         end
      end
   end

   always_comb begin
      win_we    = bus.cli_we[win_idx];
      win_lock  = bus.cli_lock[win_idx];
      win_pl    = bus.cli_player[int'(win_idx)*PW +: PW];
      win_addr  = bus.cli_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      win_wdata = bus.cli_wdata[int'(win_idx)*DATA_W +: DATA_W];
      pl_ok     = 1'b0;
      wren_d    = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (win_pl == pid_t'(p)) begin
            pl_ok     = 1'b1;
            wren_d[p] = win_vld && win_we;
         end
      end
      gnt_d = '0;
      if (win_vld) gnt_d[win_idx] = 1'b1;
      ptr_d = ptr_q;
      if (win_vld) ptr_d = (win_idx == cid_t'(NUM_CLIENTS-1)) ? '0 : win_idx + cid_t'(1);
   end

   // Out-of-range banks read back as zero rather than whatever the mux would pick.
   always_comb begin
      rvalid_d = '0;
      rdata_d  = rdata_q;
      if (pipe_vld_q[RD_LATENCY-1]) begin
         rvalid_d[pipe_id_q[RD_LATENCY-1]] = 1'b1;
         rdata_d = '0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (pipe_pl_q[RD_LATENCY-1] == pid_t'(p)) rdata_d = bus.mem_rdata[p*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge resetGeral) begin
      if (resetGeral) begin
         ptr_q     <= '0;
         own_vld_q <= 1'b0;
         own_idx_q <= '0;
         gnt_q     <= '0;
         wren_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         erro_q    <= 1'b0;
         iss_vld_q <= 1'b0;
         iss_id_q  <= '0;
         iss_pl_q  <= '0;
         for (int j = 0; j < RD_LATENCY; j++) begin
            pipe_vld_q[j] <= 1'b0;
            pipe_id_q[j]  <= '0;
            pipe_pl_q[j]  <= '0;
         end
         rvalid_q  <= '0;
         rdata_q   <= '0;
      end else begin
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         wren_q    <= wren_d;
         erro_q    <= win_vld && !pl_ok;
         iss_vld_q <= win_vld && !win_we;
         own_vld_q <= win_vld && win_lock;
         if (win_vld) begin
            own_idx_q <= win_idx;
            addr_q    <= win_addr;
            wdata_q   <= win_wdata;
            iss_id_q  <= win_idx;
            iss_pl_q  <= win_pl;
         end
         pipe_vld_q[0] <= iss_vld_q;
         pipe_id_q[0]  <= iss_id_q;
         pipe_pl_q[0]  <= iss_pl_q;
         for (int j = 1; j < RD_LATENCY; j++) begin
            pipe_vld_q[j] <= pipe_vld_q[j-1];
            pipe_id_q[j]  <= pipe_id_q[j-1];
            pipe_pl_q[j]  <= pipe_pl_q[j-1];
         end
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.cli_gnt      = gnt_q;
   assign bus.cli_rvalid   = rvalid_q;
   assign bus.cli_rdata    = rdata_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.mem_wren     = wren_q;
   assign bus.erro_jogador = erro_q;
endmodule
